// File: rtl/mcp4921_spi_tx_if.sv
// Sample-side request/status and DAC-side SPI pins of the MCP4921 transmitter.
// ldac_n exists only when MCP4921_LDAC_EN is defined.
interface mcp4921_spi_tx_if;
    logic        start;
    logic [11:0] data_in;
    logic        busy;
    logic        done;
    logic        sck;
    logic        sdo;
    logic        cs_n;
`ifdef MCP4921_LDAC_EN
    logic        ldac_n;
`endif

    modport master (
        output start, data_in,
`ifdef MCP4921_LDAC_EN
        input  ldac_n,
`endif
        input  busy, done, sck, sdo, cs_n
    );

    modport slave (
        input  start, data_in,
`ifdef MCP4921_LDAC_EN
        output ldac_n,
`endif
        output busy, done, sck, sdo, cs_n
    );
endinterface

// File: rtl/mcp4921_spi_tx.sv
// MCP4921 12-bit DAC write controller: SPI mode 0,0, MSB-first 16-bit frame.
// Optional LDAC strobe phase after each frame is enabled by MCP4921_LDAC_EN.
module mcp4921_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic        BUF     = 1'b0,
    parameter logic        GA_N    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mcp4921_spi_tx_if.slave    bus
);
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] HALF        = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] PERIOD_LAST = DIV_W'(2 * CLK_DIV - 1);

`ifdef MCP4921_LDAC_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [15:0]       shreg_q, shreg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sck_q, sck_d;
    logic              sdo_q, sdo_d;
    logic              cs_n_q, cs_n_d;
`ifdef MCP4921_LDAC_EN
    logic              ldac_n_q, ldac_n_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            cs_n_q   <= 1'b1;
`ifdef MCP4921_LDAC_EN
            ldac_n_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sck_q    <= sck_d;
            sdo_q    <= sdo_d;
            cs_n_q   <= cs_n_d;
`ifdef MCP4921_LDAC_EN
            ldac_n_q <= ldac_n_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    shreg_d = {1'b0, BUF, GA_N, 1'b1, bus.data_in};
                end
            end
            SHIFT: begin
                // End of a bit period: sck falls and the next bit moves up.
                if (div_q == PERIOD_LAST) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[14:0], 1'b0};
                    if (bit_q == 4'd15) begin
                        state_d = GAP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
`ifdef MCP4921_LDAC_EN
                    state_d = LDAC;
`else
                    state_d = IDLE;
`endif
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef MCP4921_LDAC_EN
            LDAC: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so every output leaves a flop.
    always_comb begin
        cs_n_d = (state_d != SHIFT);
        sck_d  = (state_d == SHIFT) && (div_d >= HALF);
        sdo_d  = (state_d == SHIFT) && shreg_d[15];
        busy_d = (state_d != IDLE);
`ifdef MCP4921_LDAC_EN
        ldac_n_d = (state_d != LDAC);
        done_d   = (state_d == LDAC) && (div_d == HALF_LAST);
`else
        done_d   = (state_d == GAP) && (div_d == HALF_LAST);
`endif
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sck    = sck_q;
    assign bus.sdo    = sdo_q;
    assign bus.cs_n   = cs_n_q;
`ifdef MCP4921_LDAC_EN
    assign bus.ldac_n = ldac_n_q;
`endif
endmodule

// File: tb/tb_mcp4921_spi_tx.sv
// Bench for mcp4921_spi_tx: three configurations (H=1, H=2, H=2 with BUF=1/GA_N=0)
// checked cycle by cycle against a timing-rule model plus a DAC-side capture.
module tb_mcp4921_spi_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        tb_start;
    logic [11:0] tb_data;
    int          sel;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef MCP4921_LDAC_EN
    localparam int LD = 1;
`else
    localparam int LD = 0;
`endif

    always #5 clk = ~clk;

    mcp4921_spi_tx_if if0 ();
    mcp4921_spi_tx_if if1 ();
    mcp4921_spi_tx_if if2 ();

    assign if0.start   = tb_start && (sel == 0);
    assign if1.start   = tb_start && (sel == 1);
    assign if2.start   = tb_start && (sel == 2);
    assign if0.data_in = tb_data;
    assign if1.data_in = tb_data;
    assign if2.data_in = tb_data;

    mcp4921_spi_tx #(.CLK_DIV(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    mcp4921_spi_tx #(.CLK_DIV(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    mcp4921_spi_tx #(.CLK_DIV(2), .BUF(1'b1), .GA_N(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // obs = {cs_n, sck, sdo, busy, done, ldac_n}
    logic [5:0] obs;
    always_comb begin
        logic l0, l1, l2;
`ifdef MCP4921_LDAC_EN
        l0 = if0.ldac_n; l1 = if1.ldac_n; l2 = if2.ldac_n;
`else
        l0 = 1'b1; l1 = 1'b1; l2 = 1'b1;
`endif
        case (sel)
            0:       obs = {if0.cs_n, if0.sck, if0.sdo, if0.busy, if0.done, l0};
            1:       obs = {if1.cs_n, if1.sck, if1.sdo, if1.busy, if1.done, l1};
            default: obs = {if2.cs_n, if2.sck, if2.sdo, if2.busy, if2.done, l2};
        endcase
    end

    function automatic int h_of(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] word_of(input int s, input logic [11:0] d);
        logic b, g;
        b = (s == 2);
        g = (s != 2);
        return {1'b0, b, g, 1'b1, d};
    endfunction

    // Expected pins in cycle c after the accepting edge, straight from the frame timing rules.
    function automatic logic [5:0] exp_pins(input int c, input int h, input logic [15:0] w);
        int   k, end_c;
        logic cs_n, sck, sdo, busy, done, ldac;
        end_c = (33 + LD) * h;
        cs_n = 1'b1; sck = 1'b0; sdo = 1'b0; ldac = 1'b1;
        if (c >= 1 && c <= 32 * h) begin
            k    = (c - 1) / (2 * h);
            cs_n = 1'b0;
            sck  = ((c - 1) % (2 * h)) >= h;
            sdo  = w[15 - k];
        end
        busy = (c >= 1) && (c <= end_c);
        done = (c == end_c);
        if (LD == 1 && c > 33 * h && c <= 34 * h) ldac = 1'b0;
        return {cs_n, sck, sdo, busy, done, ldac};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller leaves tb_start high before the accepting edge; inj<0 means strobe start in the done cycle.
    task automatic run_frame(input int s, input logic [11:0] d, input logic [15:0] w, input int inj);
        int          h, end_c, nrise, inj_c;
        logic [15:0] cap;
        logic        prev_sck;
        h     = h_of(s);
        end_c = (33 + LD) * h;
        inj_c = (inj < 0) ? end_c : inj;
        @(posedge clk);
        #1 tb_start = 1'b0;
        tb_data = ~d;
        cap = '0; nrise = 0; prev_sck = 1'b0;
        for (int c = 1; c <= end_c + 1; c++) begin
            @(negedge clk);
            check($sformatf("pins s%0d d%h c%0d", s, d, c), 32'(obs), 32'(exp_pins(c, h, w)));
            if (obs[4] && !prev_sck && !obs[5]) begin
                cap = {cap[14:0], obs[3]};
                nrise++;
            end
            prev_sck = obs[4];
            if (c == inj_c) begin
                tb_start = 1'b1;
                tb_data  = 12'h555;
            end else if (c == inj_c + 1) begin
                tb_start = 1'b0;
            end
        end
        check($sformatf("dac word s%0d", s), 32'(cap), 32'(w));
        check($sformatf("sck rises s%0d", s), 32'(nrise), 32'd16);
    endtask

    task automatic do_frame(input int s, input logic [11:0] d, input logic [15:0] w,
                            input int inj, input int gap);
        repeat (gap) @(negedge clk);
        sel      = s;
        tb_start = 1'b1;
        tb_data  = d;
        run_frame(s, d, w, inj);
    endtask

    typedef struct {
        int          s;
        logic [11:0] d;
        logic [15:0] w;
        int          inj;
        int          gap;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 12'hABC, 16'h3ABC,  0, 2};
        tbl[1] = '{0, 12'h000, 16'h3000,  0, 2};
        tbl[2] = '{0, 12'hFFF, 16'h3FFF,  0, 0};
        tbl[3] = '{1, 12'h2A7, 16'h32A7, 10, 2};
        tbl[4] = '{2, 12'h0F0, 16'h50F0,  0, 2};
        tbl[5] = '{0, 12'h7E1, 16'h37E1, -1, 3};
        tbl[6] = '{1, 12'h800, 16'h3800,  0, 1};

        reset = 1'b1; tb_start = 1'b0; tb_data = '0; sel = 0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check($sformatf("reset state s%0d", s), 32'(obs), 32'(6'b100001));
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_frame(tbl[i].s, tbl[i].d, tbl[i].w, tbl[i].inj, tbl[i].gap);

        // Asynchronous reset in cycle 20 of an H=2 frame.
        @(negedge clk);
        sel = 1; tb_start = 1'b1; tb_data = 12'h3C5;
        @(posedge clk);
        #1 tb_start = 1'b0;
        repeat (20) @(negedge clk);
        check("cs_n low before reset", 32'(obs[5]), 32'd0);
        #2 reset = 1'b1;
        #1 check("async reset pins", 32'(obs), 32'(6'b100001));
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (obs != 6'b100001) check($sformatf("idle after reset c%0d", c), 32'(obs), 32'(6'b100001));
        end
        check("idle after reset", 32'(obs), 32'(6'b100001));
        do_frame(1, 12'h123, 16'h3123, 0, 0);

        for (int i = 0; i < 14; i++) begin
            int          s, inj, h;
            logic [11:0] d;
            s   = $urandom_range(0, 2);
            h   = h_of(s);
            d   = 12'($urandom);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (33 + LD) * h)) : 0;
            do_frame(s, d, word_of(s, d), inj, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
